// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared types and default constants for the hiscore RAM arbiter
// Contents:
//   hs_state_t       arbiter state enum (IDLE, PAUSING, SETTLE, OWN, RELEASE)
//   DEF_SETTLE       default settle delay after pause_ack
//   DEF_IDLE_TIMEOUT default hiscore inactivity timeout
//   DEF_FIFO_DEPTH   default pending-write buffer depth (power of two)
package hiscore_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSING,
    ST_SETTLE,
    ST_OWN,
    ST_RELEASE
  } hs_state_t;

  localparam int DEF_SETTLE       = 4;
  localparam int DEF_IDLE_TIMEOUT = 255;
  localparam int DEF_FIFO_DEPTH   = 16;

endpackage

// File: rtl/hiscore_wr_fifo.sv
// rtl/hiscore_wr_fifo.sv - synchronous FIFO holding hiscore writes awaiting RAM ownership
// Ports:
//   clk, reset   clock, synchronous active-high reset (empties the FIFO)
//   push, din    enqueue din; ignored when full
//   pop          dequeue head; ignored when empty
//   full, empty  occupancy flags
//   head         oldest entry (valid when not empty)
module hiscore_wr_fifo
  import hiscore_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// rtl/hiscore_ram_arbiter.sv - shares the game work RAM between the CPU and the hiscore block
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   hs_address, hs_data, hs_write     hiscore RAM port
//   hs_din                            registered readback to the hiscore block
//   cpu_addr, cpu_dout, cpu_we        CPU RAM port
//   pause_req / pause_ack             CPU halt handshake
//   ram_addr, ram_din, ram_we         muxed port to the single-port RAM
//   ram_dout                          RAM read data (one cycle after address)
//   hs_busy                           arbiter not idle
//   ovf                               sticky pending-write overflow
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int AW           = 10,
  parameter int SETTLE       = DEF_SETTLE,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] hs_address,
  input  logic [7:0]    hs_data,
  input  logic          hs_write,
  output logic [7:0]    hs_din,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          hs_busy,
  output logic          ovf
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(IDLE_TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  hs_state_t     state;
  hs_state_t     state_nxt;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_nxt;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;
  logic          pend;
  logic          pend_nxt;
  logic [AW-1:0] hs_address_q;
  logic          direct_q;
  logic          activity;
  logic          own;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW+7:0] fifo_head;

  assign activity  = hs_write | (hs_address != hs_address_q);
  assign own       = (state == ST_OWN);
  // Writes bypass the FIFO only when the hiscore side already owns an empty queue.
  assign fifo_push = hs_write & ~(own & fifo_empty);
  // A falling pause_ack aborts ownership; the head stays queued for the next grant.
  assign fifo_pop  = own & pause_ack & ~fifo_empty;

  hiscore_wr_fifo #(
    .W     (AW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({hs_address, hs_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    idle_nxt   = idle_cnt;
    pend_nxt   = pend;
    case (state)
      ST_IDLE: begin
        pend_nxt = 1'b0;
        if (activity | pend | ~fifo_empty) begin
          state_nxt = ST_PAUSING;
        end
      end
      ST_PAUSING: begin
        if (pause_ack) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!pause_ack) begin
          state_nxt = ST_PAUSING;
        end else if (settle_cnt == '0) begin
          state_nxt = ST_OWN;
          idle_nxt  = '0;
        end else begin
          settle_nxt = settle_cnt - 1'b1;
        end
      end
      ST_OWN: begin
        if (activity | ~fifo_empty) begin
          idle_nxt = '0;
        end else if (idle_cnt != IDLE_MAX) begin
          idle_nxt = idle_cnt + 1'b1;
        end
        if (!pause_ack) begin
          state_nxt = ST_PAUSING;
          idle_nxt  = '0;
        end else if (idle_nxt == IDLE_MAX) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Remember activity seen while handing the port back so IDLE re-requests.
        pend_nxt  = activity;
        idle_nxt  = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    hs_address_q <= hs_address;
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      idle_cnt   <= '0;
      pend       <= 1'b0;
      direct_q   <= 1'b0;
      hs_din     <= 8'h00;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      idle_cnt   <= idle_nxt;
      pend       <= pend_nxt;
      direct_q   <= own & fifo_empty;
      if (direct_q) begin
        hs_din <= ram_dout;
      end
      if (fifo_push & fifo_full) begin
        ovf <= 1'b1;
      end
    end
  end

  // Reset forces the CPU path immediately so nothing hits the RAM during reset.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_we;
    if (!reset) begin
      case (state)
        ST_OWN: begin
          if (!fifo_empty) begin
            {ram_addr, ram_din} = fifo_head;
            ram_we              = 1'b1;
          end else begin
            ram_addr = hs_address;
            ram_din  = hs_data;
            ram_we   = hs_write;
          end
        end
        ST_RELEASE: ram_we = 1'b0;
        default: ;
      endcase
    end
  end

  assign pause_req = ~reset & ((state == ST_PAUSING) | (state == ST_SETTLE) | own);
  assign hs_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb/tb_hiscore_ram_arbiter.sv - self-checking bench for hiscore_ram_arbiter
module tb_hiscore_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hs_address;
  logic [7:0] hs_data;
  logic       hs_write;
  logic [7:0] hs_din;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_we;
  logic       pause_req;
  logic       pause_ack;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic       hs_busy;
  logic       ovf;

  logic [7:0] mem [1024];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data valid one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  hiscore_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .hs_address (hs_address),
    .hs_data    (hs_data),
    .hs_write   (hs_write),
    .hs_din     (hs_din),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .pause_req  (pause_req),
    .pause_ack  (pause_ack),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .hs_busy    (hs_busy),
    .ovf        (ovf)
  );

  typedef struct {
    logic       hw;
    logic [9:0] ha;
    logic [7:0] hd;
    logic       cw;
    logic [9:0] ca;
    logic [7:0] cd;
    logic       ack;
    logic       e_we;
    logic [9:0] e_addr;
    logic [7:0] e_din;
    logic       e_pr;
    logic       e_busy;
  } vec_t;

  vec_t tv [15];

  function automatic vec_t mk(input logic hw, input logic [9:0] ha, input logic [7:0] hd,
                              input logic cw, input logic [9:0] ca, input logic [7:0] cd,
                              input logic ack, input logic e_we, input logic [9:0] e_addr,
                              input logic [7:0] e_din, input logic e_pr, input logic e_busy);
    vec_t v;
    v.hw = hw; v.ha = ha; v.hd = hd; v.cw = cw; v.ca = ca; v.cd = cd; v.ack = ack;
    v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din; v.e_pr = e_pr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks sample 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    hs_write  = 1'b0;
    cpu_we    = 1'b0;
    pause_ack = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] got [$];
    logic [17:0] expq [$];
    logic [17:0] e;
    logic        done;
    logic        wrote;
    int          issued;
    int          written;
    int          ack_dly;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset = 1'b1; hs_address = '0; hs_data = '0; hs_write = 1'b0;
    cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0; pause_ack = 1'b0;

    //              hw  ha      hd     cw  ca      cd     ack  we  addr    din    pr  busy
    tv[0]  = mk(1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0);
    tv[1]  = mk(1'b0, 10'h000, 8'h00, 1'b1, 10'h010, 8'h5A, 1'b0, 1'b1, 10'h010, 8'h5A, 1'b0, 1'b0);
    tv[2]  = mk(1'b1, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b0, 1'b0, 10'h010, 8'h5A, 1'b0, 1'b0);
    tv[3]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b0, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[4]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b0, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[5]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[6]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[7]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[8]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[9]  = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1);
    tv[10] = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1, 10'h123, 8'h0B, 1'b1, 1'b1);
    tv[11] = mk(1'b0, 10'h123, 8'h0B, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b0, 10'h123, 8'h0B, 1'b1, 1'b1);
    tv[12] = mk(1'b1, 10'h0C4, 8'h3C, 1'b0, 10'h010, 8'h5A, 1'b1, 1'b1, 10'h0C4, 8'h3C, 1'b1, 1'b1);
    tv[13] = mk(1'b0, 10'h0C4, 8'h3C, 1'b1, 10'h010, 8'h5A, 1'b0, 1'b0, 10'h0C4, 8'h3C, 1'b1, 1'b1);
    tv[14] = mk(1'b0, 10'h0C4, 8'h3C, 1'b1, 10'h010, 8'h5A, 1'b0, 1'b1, 10'h010, 8'h5A, 1'b1, 1'b1);

    // ---------------- reset state and handshake table ----------------
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    chk("reset_hs_din", hs_din, 0);
    chk("reset_ovf", ovf, 0);
    for (int i = 0; i < 15; i++) begin
      hs_write = tv[i].hw; hs_address = tv[i].ha; hs_data = tv[i].hd;
      cpu_we = tv[i].cw; cpu_addr = tv[i].ca; cpu_dout = tv[i].cd; pause_ack = tv[i].ack;
      #1;
      chk($sformatf("tv%0d_ram_we", i), ram_we, tv[i].e_we);
      chk($sformatf("tv%0d_ram_addr", i), ram_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_ram_din", i), ram_din, tv[i].e_din);
      chk($sformatf("tv%0d_pause_req", i), pause_req, tv[i].e_pr);
      chk($sformatf("tv%0d_hs_busy", i), hs_busy, tv[i].e_busy);
      next_cycle();
    end

    // ---------------- overflow: 20 writes before pause_ack ----------------
    cpu_we = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      hs_write = 1'b1; hs_address = 10'h200 + 10'(i); hs_data = 8'h80 + 8'(i);
      next_cycle();
    end
    hs_write = 1'b0; pause_ack = 1'b1;
    got = {};
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (ram_we) got.push_back({ram_addr, ram_din});
      if (!hs_busy) done = 1'b1;
      else next_cycle();
    end
    chk("A_released", done, 1);
    chk("A_write_count", got.size(), 16);
    chk("A_ovf", ovf, 1);
    for (int k = 0; k < 16; k++) begin
      if (k < got.size()) begin
        e = {10'h200 + 10'(k), 8'h80 + 8'(k)};
        chk($sformatf("A_order%0d", k), got[k], e);
      end
    end

    // ---------------- readback latency and idle timeout ----------------
    do_reset();
    #1;
    chk("B_ovf_cleared", ovf, 0);
    chk("B_reset_busy", hs_busy, 0);
    mem[10'h2A0] = 8'h77;
    hs_write = 1'b1; hs_address = 10'h100; hs_data = 8'h11; pause_ack = 1'b1;
    next_cycle();
    hs_write = 1'b0;
    repeat (5) next_cycle();
    #1;
    chk("B_first_own_addr", {ram_we, ram_addr, ram_din}, {1'b1, 10'h100, 8'h11});
    next_cycle();
    hs_address = 10'h2A0;
    next_cycle();
    next_cycle();
    #1;
    chk("B_hs_din", hs_din, 8'h77);
    repeat (253) next_cycle();
    #1;
    chk("C_still_own_pr", pause_req, 1);
    next_cycle();
    cpu_we = 1'b1; cpu_addr = 10'h055; cpu_dout = 8'hEE;
    hs_write = 1'b1; hs_data = 8'h99;
    #1;
    chk("C_release_pr", pause_req, 0);
    chk("C_release_we", ram_we, 0);
    chk("C_release_addr", ram_addr, 10'h055);
    chk("C_release_busy", hs_busy, 1);
    next_cycle();
    hs_write = 1'b0;
    #1;
    chk("C_idle_busy", hs_busy, 0);
    chk("C_idle_cpu_port", {ram_we, ram_addr, ram_din}, {1'b1, 10'h055, 8'hEE});
    cpu_we = 1'b0;
    next_cycle();
    #1;
    chk("C_repause_pr", pause_req, 1);
    repeat (5) next_cycle();
    hs_data = 8'h44;
    #1;
    chk("C_queued_write", {ram_we, ram_addr, ram_din}, {1'b1, 10'h2A0, 8'h99});
    next_cycle();
    #1;
    chk("C_single_entry", {ram_we, ram_din}, {1'b0, 8'h44});

    // ---------------- reset during OWN with queued writes ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hs_write = 1'b1; hs_address = 10'h301 + 10'(i); hs_data = 8'hA1 + 8'(i);
      next_cycle();
    end
    hs_write = 1'b0; pause_ack = 1'b1;
    repeat (5) next_cycle();
    #1;
    chk("D_own_head", {ram_we, ram_addr, ram_din}, {1'b1, 10'h301, 8'hA1});
    reset = 1'b1;
    #1;
    chk("D_reset_pr", pause_req, 0);
    chk("D_reset_we", ram_we, 0);
    next_cycle();
    reset = 1'b0; pause_ack = 1'b0;
    wrote = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ram_we) wrote = 1'b1;
      next_cycle();
    end
    chk("D_no_write_after_reset", wrote, 0);
    chk("D_pr_after_reset", pause_req, 0);
    chk("D_busy_after_reset", hs_busy, 0);

    // ---------------- randomized traffic against a write scoreboard ----------------
    do_reset();
    expq = {}; issued = 0; written = 0; ack_dly = 0;
    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < ((ph % 2 == 0) ? 150 : 320); c++) begin
        if (ph % 2 == 0) begin
          if ($urandom_range(0, 3) == 0) hs_address = 10'($urandom_range(0, 1023));
          hs_write = ($urandom_range(0, 2) == 0) && (issued - written < 12);
          hs_data  = 8'($urandom);
        end else begin
          hs_write = 1'b0;
        end
        if (pause_req) begin
          if (!pause_ack) begin
            if (ack_dly == 0) pause_ack = 1'b1;
            else ack_dly--;
          end
        end else begin
          pause_ack = 1'b0;
          ack_dly   = $urandom_range(0, 5);
        end
        if (hs_write) begin
          expq.push_back({hs_address, hs_data});
          issued++;
        end
        #1;
        if (ram_we) begin
          chk("R_write_expected", expq.size() > 0, 1);
          chk("R_write_while_halted", pause_ack, 1);
          if (expq.size() > 0) chk("R_write_order", {ram_addr, ram_din}, expq.pop_front());
          written++;
        end
        next_cycle();
      end
    end
    hs_write = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (pause_req) pause_ack = 1'b1;
      else pause_ack = 1'b0;
      #1;
      if (ram_we) begin
        chk("R_drain_expected", expq.size() > 0, 1);
        if (expq.size() > 0) chk("R_drain_order", {ram_addr, ram_din}, expq.pop_front());
      end
      if (!hs_busy && expq.size() == 0) done = 1'b1;
      else next_cycle();
    end
    chk("R_drained", expq.size(), 0);
    chk("R_idle_at_end", hs_busy, 0);
    chk("R_no_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_arbiter.md
Name: hiscore_ram_arbiter

Overview:
- Sits directly downstream of the hiscore block, between its RAM port (ram_address / data_to_ram / ram_write, plus the ioctl_din readback) and the single-port game work RAM that the CPU also drives.
- Detects hiscore activity and pauses the CPU through a request/acknowledge handshake.
- Buffers hiscore writes issued before ownership is granted, then gives the RAM port to the hiscore side.
- Returns the CPU to the RAM port after an idle timeout.

Parameters:
- AW, 10, game RAM address width.
- SETTLE, 4, cycles to wait after pause_ack before taking the RAM port.
- IDLE_TIMEOUT, 255, cycles of hiscore inactivity before release.
- FIFO_DEPTH, 16, pending-write buffer depth; must be a power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hs_address  in  AW  hiscore RAM address
- hs_data  in  8  hiscore write data
- hs_write  in  1  hiscore write strobe, one write per cycle high
- hs_din  out  8  readback to hiscore (its ioctl_din)
- cpu_addr  in  AW  CPU address
- cpu_dout  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- pause_req  out  1  CPU pause request
- pause_ack  in  1  CPU is halted
- ram_addr  out  AW  to RAM
- ram_din  out  8  to RAM
- ram_we  out  1  to RAM
- ram_dout  in  8  RAM read data; synchronous RAM, valid one cycle after address
- hs_busy  out  1  high in any state other than IDLE
- ovf  out  1  sticky FIFO-overflow flag; cleared only by reset

Behaviour:
- Reset:
  - state IDLE, pause_req=0, hs_din=0, ovf=0, FIFO empty, idle counter 0.
  - RAM mux selects the CPU, so ram_we follows cpu_we.
- Activity: hs_write=1, or hs_address differs from its value registered the previous cycle.
- RAM mux (combinational, select registered):
  - IDLE / PAUSING / SETTLE: CPU drives ram_addr, ram_din, ram_we.
  - OWN with FIFO non-empty: FIFO head drives ram_addr and ram_din, ram_we=1.
  - OWN with FIFO empty: hs_address and hs_data drive the port, ram_we=hs_write.
  - RELEASE: CPU address on the port, ram_we forced to 0.
- FIFO: entries are {addr, data}.
  - Enqueue on hs_write in any state except OWN-with-FIFO-empty.
  - Dequeue one entry per OWN cycle.
  - Enqueue while full drops the write and sets ovf.
  - Simultaneous enqueue and dequeue in the same cycle is legal; count is unchanged.
- States:
  - IDLE: on activity go to PAUSING and set pause_req=1.
  - PAUSING: wait for pause_ack=1, then load the settle counter with SETTLE-1 and go to SETTLE.
  - SETTLE: count down; at 0 go to OWN. pause_ack falling returns to PAUSING.
  - OWN:
    - Idle counter clears on activity or FIFO non-empty, otherwise increments.
    - At IDLE_TIMEOUT go to RELEASE.
    - pause_ack falling goes to PAUSING; the FIFO is kept and its head is not popped that cycle.
  - RELEASE (1 cycle): pause_req=0, go to IDLE.
    - Activity in this cycle is latched, and IDLE moves to PAUSING on the next cycle.
    - Any write in this cycle is enqueued.
- hs_din: registered ram_dout, updated only when the previous cycle was OWN with the FIFO empty; otherwise holds its value. Readback latency is 2 cycles from hs_address.
- Reset mid-operation: immediate return to reset values, pause_req drops the same cycle, pending FIFO contents are discarded.
- Counter widths: $clog2(IDLE_TIMEOUT+1) and $clog2(SETTLE+1). The idle counter saturates.

Decomposition:
- Shared package hiscore_pkg holds:
  - the state enum (IDLE, PAUSING, SETTLE, OWN, RELEASE);
  - default constants for SETTLE, IDLE_TIMEOUT and FIFO_DEPTH.
- One sub-module, hiscore_wr_fifo: synchronous FIFO with parameters AW+8 bits × FIFO_DEPTH and ports push, pop, full, empty, head.

Test Plan:
- Reset, CPU writes 0x5A to 0x010 → ram_we=1, ram_addr=0x010, pause_req=0, hs_busy=0.
- hs_write 0x0B to 0x123 in IDLE, pause_ack 3 cycles later → pause_req high the next cycle; SETTLE 4 cycles; first OWN cycle shows ram_we=1, addr 0x123, data 0x0B.
- 20 hs_writes before pause_ack → 16 drained in order in OWN, ovf=1, the last 4 writes never reach the RAM.
- In OWN, RAM[0x2A0]=0x77, hs_address changes to 0x2A0 → hs_din=0x77 two cycles later.
- No activity for 255 cycles in OWN → RELEASE for 1 cycle with ram_we=0, then IDLE and CPU regains the port; an hs_write in the RELEASE cycle re-enters PAUSING with 1 FIFO entry.
- reset asserted in OWN with 3 queued writes → pause_req=0 the same cycle, FIFO empty, no RAM write after reset.
